// File: rtl/display_scan_decoder.sv
// Multiplexed 7-segment display scan decoder.
// Samples the anode and cathode buses, captures each steady scan step once,
// decodes the segment pattern into a hex nibble and gathers one frame of
// digits in a shadow store. The shadow is committed to the outputs when the
// scan wraps back to an index at or before the last captured one.
module display_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  an,
   input  logic [7:0]  dec_cat,
   output logic [31:0] digits,
   output logic [7:0]  digit_en,
   output logic [7:0]  dp,
   output logic [7:0]  digit_err,
   output logic        frame_done,
   output logic        an_error
);

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned NDIG     = 8;
   localparam int unsigned IDX_W    = 3;

   // Sample pipeline and stability counter
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [SAMPLE_W-1:0] prev_q, prev_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cap_stb;

   // Anode and segment decode of the captured sample
   logic [NDIG-1:0]     an_low;
   logic                an_single;
   logic                an_multi;
   logic [IDX_W-1:0]    an_idx;
   logic [6:0]          seg_act;
   logic                cap_dp;
   logic                dec_ok;
   logic [3:0]          dec_nib;

   // Shadow frame store and last captured index
   logic [31:0]         sh_dig_q, sh_dig_d;
   logic [NDIG-1:0]     sh_en_q, sh_en_d;
   logic [NDIG-1:0]     sh_dp_q, sh_dp_d;
   logic [NDIG-1:0]     sh_err_q, sh_err_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic                last_vld_q, last_vld_d;

   // Committed outputs
   logic [31:0]         digits_q, digits_d;
   logic [NDIG-1:0]     digit_en_q, digit_en_d;
   logic [NDIG-1:0]     dp_q, dp_d;
   logic [NDIG-1:0]     digit_err_q, digit_err_d;
   logic                frame_done_q, frame_done_d;
   logic                an_error_q, an_error_d;

   // Hex decode of an active-high abcdefg pattern; bit 4 flags a legal glyph
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      case (s)
         7'b1111110: return {1'b1, 4'h0};
         7'b0110000: return {1'b1, 4'h1};
         7'b1101101: return {1'b1, 4'h2};
         7'b1111001: return {1'b1, 4'h3};
         7'b0110011: return {1'b1, 4'h4};
         7'b1011011: return {1'b1, 4'h5};
         7'b1011111: return {1'b1, 4'h6};
         7'b1110000: return {1'b1, 4'h7};
         7'b1111111: return {1'b1, 4'h8};
         7'b1111011: return {1'b1, 4'h9};
         7'b1110111: return {1'b1, 4'hA};
         7'b0011111: return {1'b1, 4'hB};
         7'b1001110: return {1'b1, 4'hC};
         7'b0111101: return {1'b1, 4'hD};
         7'b1001111: return {1'b1, 4'hE};
         7'b1000111: return {1'b1, 4'hF};
         default:    return 5'b0_0000;
      endcase
   endfunction

   // Stability tracking: capture fires once, when the counter reaches the threshold
   always_comb begin
      sample_d = {an, dec_cat};
      prev_d   = sample_q;
      cnt_d    = cnt_q;
      cap_stb  = 1'b0;
      if (sample_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            cap_stb = 1'b1;
         end
      end
   end

   // Decode anode selection and segment glyph of the steady sample
   always_comb begin
      an_low    = ~prev_q[15:8];
      an_single = (an_low != '0) && ((an_low & (an_low - NDIG'(1))) == '0);
      an_multi  = (an_low != '0) && !an_single;
      an_idx    = '0;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (an_low[k]) begin
            an_idx = IDX_W'(k);
         end
      end
      seg_act = ~prev_q[7:1];
      cap_dp  = ~prev_q[0];
      {dec_ok, dec_nib} = decode_seg(seg_act);
   end

   // Shadow update, wrap detection and commit to the outputs
   always_comb begin
      sh_dig_d     = sh_dig_q;
      sh_en_d      = sh_en_q;
      sh_dp_d      = sh_dp_q;
      sh_err_d     = sh_err_q;
      last_d       = last_q;
      last_vld_d   = last_vld_q;
      digits_d     = digits_q;
      digit_en_d   = digit_en_q;
      dp_d         = dp_q;
      digit_err_d  = digit_err_q;
      frame_done_d = 1'b0;
      an_error_d   = 1'b0;
      if (cap_stb) begin
         if (an_multi) begin
            an_error_d = 1'b1;
         end else if (an_single) begin
            // Wrap: revisiting an index at or before the last one closes the frame
            if (last_vld_q && (an_idx <= last_q)) begin
               digits_d     = sh_dig_q;
               digit_en_d   = sh_en_q;
               dp_d         = sh_dp_q;
               digit_err_d  = sh_err_q;
               frame_done_d = 1'b1;
               sh_dig_d     = '0;
               sh_en_d      = '0;
               sh_dp_d      = '0;
               sh_err_d     = '0;
            end
            sh_dig_d[{an_idx, 2'b00} +: 4] = dec_ok ? dec_nib : 4'h0;
            sh_en_d[an_idx]  = 1'b1;
            sh_dp_d[an_idx]  = cap_dp;
            sh_err_d[an_idx] = !dec_ok;
            last_d           = an_idx;
            last_vld_d       = 1'b1;
         end
      end
   end

   // State registers; idle sample is the all-high (blank) bus
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sample_q     <= '1;
         prev_q       <= '1;
         cnt_q        <= '0;
         sh_dig_q     <= '0;
         sh_en_q      <= '0;
         sh_dp_q      <= '0;
         sh_err_q     <= '0;
         last_q       <= '0;
         last_vld_q   <= 1'b0;
         digits_q     <= '0;
         digit_en_q   <= '0;
         dp_q         <= '0;
         digit_err_q  <= '0;
         frame_done_q <= 1'b0;
         an_error_q   <= 1'b0;
      end else begin
         sample_q     <= sample_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         sh_dig_q     <= sh_dig_d;
         sh_en_q      <= sh_en_d;
         sh_dp_q      <= sh_dp_d;
         sh_err_q     <= sh_err_d;
         last_q       <= last_d;
         last_vld_q   <= last_vld_d;
         digits_q     <= digits_d;
         digit_en_q   <= digit_en_d;
         dp_q         <= dp_d;
         digit_err_q  <= digit_err_d;
         frame_done_q <= frame_done_d;
         an_error_q   <= an_error_d;
      end
   end

   assign digits     = digits_q;
   assign digit_en   = digit_en_q;
   assign dp         = dp_q;
   assign digit_err  = digit_err_q;
   assign frame_done = frame_done_q;
   assign an_error   = an_error_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder with hand-computed expectations.
module tb_display_scan_decoder;

   logic        clock;
   logic        reset;
   logic [7:0]  an;
   logic [7:0]  dec_cat;
   logic [31:0] digits;
   logic [7:0]  digit_en;
   logic [7:0]  dp;
   logic [7:0]  digit_err;
   logic        frame_done;
   logic        an_error;

   int n_checks = 0;
   int n_errors = 0;
   int fd_cnt   = 0;
   int ae_cnt   = 0;
   int fd_base;
   int ae_base;

   // abcdefg glyphs for 0..F, active-high
   logic [6:0] seg_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   display_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .an         (an),
      .dec_cat    (dec_cat),
      .digits     (digits),
      .digit_en   (digit_en),
      .dp         (dp),
      .digit_err  (digit_err),
      .frame_done (frame_done),
      .an_error   (an_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count output pulses shortly after each rising edge
   always @(posedge clock) begin
      #1;
      if (frame_done) fd_cnt++;
      if (an_error)   ae_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] cat_of(input logic [3:0] nib, input logic dpv);
      logic [6:0] s;
      s = seg_tab[nib];
      return {~s, ~dpv};
   endfunction

   // Drive one scan step and hold it for a number of clocks
   task automatic show(input int idx, input logic [7:0] cat, input int hold);
      logic [7:0] one;
      one = 8'd1;
      an      = ~(one << idx);
      dec_cat = cat;
      repeat (hold) @(negedge clock);
   endtask

   task automatic show_raw(input logic [7:0] a, input logic [7:0] cat, input int hold);
      an      = a;
      dec_cat = cat;
      repeat (hold) @(negedge clock);
   endtask

   task automatic scan_0_7;
      for (int k = 0; k < 8; k++) show(k, cat_of(4'(k), 1'b0), 10);
   endtask

   task automatic check_outs(input string tag, input logic [31:0] d, input logic [7:0] en,
                             input logic [7:0] p, input logic [7:0] e);
      check({tag, "_digits"}, digits, d);
      check({tag, "_en"}, 32'(digit_en), 32'(en));
      check({tag, "_dp"}, 32'(dp), 32'(p));
      check({tag, "_err"}, 32'(digit_err), 32'(e));
   endtask

   initial begin
      reset   = 1'b0;
      an      = 8'hFF;
      dec_cat = 8'hFF;
      repeat (3) @(negedge clock);
      check_outs("reset", 32'h0, 8'h00, 8'h00, 8'h00);
      check("reset_fd", 32'(frame_done), 32'd0);
      check("reset_ae", 32'(an_error), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Two full scans of 0..7
      fd_base = fd_cnt;
      scan_0_7();
      check("scan1_fd", 32'(fd_cnt - fd_base), 32'd0);
      check_outs("scan1", 32'h0, 8'h00, 8'h00, 8'h00);
      show(0, cat_of(4'h0, 1'b0), 10);
      check("scan2_first_fd", 32'(fd_cnt - fd_base), 32'd1);
      for (int k = 1; k < 8; k++) show(k, cat_of(4'(k), 1'b0), 10);
      check("scan2_fd", 32'(fd_cnt - fd_base), 32'd1);
      check_outs("scan2", 32'h76543210, 8'hFF, 8'h00, 8'h00);

      // Sparse scan: d1 "A" with dp, d3 "5"
      fd_base = fd_cnt;
      for (int r = 0; r < 3; r++) begin
         show(0, cat_of(4'hA, 1'b1), 10);
         show(2, cat_of(4'h5, 1'b0), 10);
      end
      check("sparse_fd", 32'(fd_cnt - fd_base), 32'd3);
      check_outs("sparse", 32'h0000050A, 8'h05, 8'h01, 8'h00);

      // Too-short holds and blanking never capture
      fd_base = fd_cnt;
      show(3, cat_of(4'h9, 1'b0), 3);
      show_raw(8'hFF, 8'hFF, 10);
      show(4, cat_of(4'h8, 1'b0), 4);
      check("short_fd", 32'(fd_cnt - fd_base), 32'd0);
      check_outs("short_hold", 32'h0000050A, 8'h05, 8'h01, 8'h00);
      show(0, cat_of(4'h1, 1'b0), 10);
      check("short_wrap_fd", 32'(fd_cnt - fd_base), 32'd1);
      check_outs("short_commit", 32'h0000050A, 8'h05, 8'h01, 8'h00);

      // Illegal anode pattern, then undecodable glyph on d2
      ae_base = ae_cnt;
      fd_base = fd_cnt;
      show_raw(8'hFC, cat_of(4'h3, 1'b0), 10);
      check("an_err_pulse", 32'(ae_cnt - ae_base), 32'd1);
      check("an_err_fd", 32'(fd_cnt - fd_base), 32'd0);
      show(1, 8'h55, 10);
      show(0, cat_of(4'h2, 1'b0), 10);
      check_outs("bad_glyph", 32'h00000001, 8'h03, 8'h00, 8'h02);

      // All segments off with dp on d3, then repeated index d1 twice
      show(2, 8'hFE, 10);
      show(0, cat_of(4'hF, 1'b0), 10);
      check_outs("blank_glyph", 32'h00000002, 8'h05, 8'h04, 8'h04);
      fd_base = fd_cnt;
      show(0, cat_of(4'hE, 1'b0), 10);
      check("repeat_fd", 32'(fd_cnt - fd_base), 32'd1);
      check_outs("repeat_idx", 32'h0000000F, 8'h01, 8'h00, 8'h00);

      // Reset in the middle of a frame
      scan_0_7();
      for (int k = 0; k < 3; k++) show(k, cat_of(4'(k + 8), 1'b1), 10);
      reset = 1'b0;
      an    = 8'hFF;
      dec_cat = 8'hFF;
      repeat (3) @(negedge clock);
      check_outs("mid_reset", 32'h0, 8'h00, 8'h00, 8'h00);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      fd_base = fd_cnt;
      scan_0_7();
      check("post_rst1_fd", 32'(fd_cnt - fd_base), 32'd0);
      check_outs("post_rst1", 32'h0, 8'h00, 8'h00, 8'h00);
      scan_0_7();
      check("post_rst2_fd", 32'(fd_cnt - fd_base), 32'd1);
      check_outs("post_rst2", 32'h76543210, 8'hFF, 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/display_scan_decoder.md
DISPLAY_SCAN_DECODER -- requirements
Module: display_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive unchanged samples required before a digit is captured (legal range 2..255).
REQ-002 clock  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 an  input  8  anode bus, active-low; an[i] low selects digit i+1 (an[0] = d1 ... an[7] = d8).
REQ-005 dec_cat  input  8  cathode bus, active-low; dec_cat[7:1] = segments a..g, dec_cat[0] = decimal point.
REQ-006 digits  output  32  committed hex values; digits[4i+3:4i] = digit i+1.
REQ-007 digit_en  output  8  committed per-digit "seen in last frame" flags.
REQ-008 dp  output  8  committed per-digit decimal point, active-high.
REQ-009 digit_err  output  8  committed per-digit "segment pattern not decodable" flags.
REQ-010 frame_done  output  1  one-cycle pulse; committed outputs updated on this edge.
REQ-011 an_error  output  1  one-cycle pulse on capture of an illegal anode pattern.

Function
REQ-012 The block SHALL register {an, dec_cat} once per clock and evaluate stability on the registered sample only.
REQ-013 A stability counter SHALL reset to 0 whenever the registered sample differs from the previous one, and SHALL saturate at STABLE_CYCLES.
REQ-014 Capture SHALL occur exactly once per steady period, on the edge where the counter reaches STABLE_CYCLES (STABLE_CYCLES+1 clocks after the pins settle); there SHALL be no re-capture until the sample changes.
REQ-015 At capture, an all-high an SHALL be ignored (blanking interval); more than one low bit SHALL pulse an_error and otherwise be ignored.
REQ-016 At capture with exactly one low anode bit i, segments SHALL be inverted to active-high and decoded via abcdefg patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-017 A decoded capture SHALL write shadow nibble i, set shadow en[i], set shadow dp[i] = ~dec_cat[0], and clear shadow err[i].
REQ-018 An undecodable pattern (including all segments off) SHALL write shadow nibble i = 0, set shadow en[i] and err[i], and store dp as in REQ-017.
REQ-019 Frame wrap SHALL be detected when a valid capture has index i <= the last valid captured index of the current frame.
REQ-020 On wrap, the block SHALL in one edge copy shadow digits/en/dp/err to the outputs, pulse frame_done, clear the shadow, then store the wrapping capture into the cleared shadow.
REQ-021 Digits not captured during a frame SHALL be committed with digit_en=0, nibble 0, dp 0, err 0.
REQ-022 A repeated capture of the same index within a frame counts as wrap (i <= last), not overwrite.
REQ-023 The first valid capture after reset SHALL NOT cause a commit (no last index yet).
REQ-024 Committed outputs SHALL hold between frame_done pulses, independent of input activity.

Reset
REQ-025 While reset is low, digits, digit_en, dp, digit_err SHALL be 0, frame_done and an_error 0, the shadow cleared, the stability counter 0, and the last index invalid.
REQ-026 Reset asserted mid-frame SHALL discard the shadow without committing; the first frame_done after release SHALL occur only at the second wrap-capable capture.

Verification
REQ-027 Scan d1..d8 showing 0..7, each held 10 clocks, two full scans -> frame_done once at start of the 2nd scan; digits=32h76543210, digit_en=8hFF, dp=0, digit_err=0.
REQ-028 Scan only an[0] ("A", dp on) and an[2] ("5") repeatedly -> after wrap digits[3:0]=A, digits[11:8]=5, digit_en=8h05, dp=8h01.
REQ-029 Apply a steady pattern for STABLE_CYCLES-1 clocks only, then change -> no capture; shadow unchanged, no frame_done.
REQ-030 Capture with an=8hFC -> an_error single-cycle pulse, no shadow change; capture with segments 1010101 on an[1] -> after wrap digit_err=8h02, digits[7:4]=0.
REQ-031 Assert reset during second frame, release, rescan 0..7 twice -> outputs 0 until first post-reset wrap, then REQ-027 values.
